// File: rtl/main_mem_mp.sv
// Multi-port main memory: one read/write port plus RPORTS read-only ports.
// A clear sequencer zeroes every word after reset or on request; all ports
// are not-ready while it runs. Reads return through a registered 1-cycle
// path with a valid strobe. Storage is replicated once per read port, and
// every write (RW port or clear sweep) lands in all replicas identically.
module main_mem_mp #(
  parameter int AW          = 8,
  parameter int DW          = 16,
  parameter int RPORTS      = 2,
  parameter int WRITE_FIRST = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_req_i,
  output logic                 busy_o,
  input  logic                 rw_val_i,
  input  logic                 rw_wen_i,
  input  logic [AW-1:0]        rw_addr_i,
  input  logic [DW-1:0]        rw_wdata_i,
  output logic                 rw_rdy_o,
  output logic                 rw_rvalid_o,
  output logic [DW-1:0]        rw_rdata_o,
  input  logic [RPORTS-1:0]    r_val_i,
  input  logic [RPORTS*AW-1:0] r_addr_i,
  output logic [RPORTS-1:0]    r_rdy_o,
  output logic [RPORTS-1:0]    r_rvalid_o,
  output logic [RPORTS*DW-1:0] r_rdata_o
);

  localparam int            DEPTH    = 1 << AW;
  localparam logic [AW-1:0] PTR_LAST = '1;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  // Shared write port into every replica.
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic              ready;
  logic              rw_acc;
  logic [RPORTS-1:0] r_acc;

  logic [DW-1:0] mem_q [RPORTS][DEPTH];
  logic [DW-1:0] rd_word [RPORTS];

  logic                 rw_rvalid_q;
  logic [DW-1:0]        rw_rdata_q;
  logic [RPORTS-1:0]    r_rvalid_q;
  logic [RPORTS*DW-1:0] r_rdata_q;

  assign ready  = (state_q == READY);
  assign rw_acc = rw_val_i & ready;
  assign r_acc  = r_val_i & {RPORTS{ready}};

  // State and sweep-pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst_ni) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic and selection of the single write source.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    wr_addr = rw_addr_i;
    wr_data = rw_wdata_i;
    unique case (state_q)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = ptr_q;
        wr_data = '0;
        ptr_d   = ptr_q + AW'(1);
        if (ptr_q == PTR_LAST) begin
          state_d = READY;
          ptr_d   = '0;
        end
      end
      READY: begin
        wr_en = rw_acc & rw_wen_i;
        if (clr_req_i) state_d = CLEAR;
      end
      default: state_d = CLEAR;
    endcase
  end

  // Per-port read word, with optional write-first bypass on a collision.
  always_comb begin
    for (int k = 0; k < RPORTS; k++) begin
      if ((WRITE_FIRST != 0) && wr_en && ready &&
          (r_addr_i[k*AW +: AW] == rw_addr_i)) begin
        rd_word[k] = rw_wdata_i;
      end else begin
        rd_word[k] = mem_q[k][r_addr_i[k*AW +: AW]];
      end
    end
  end

  // Replicated storage: one array per read port, all written identically.
  always_ff @(posedge clk_i) begin
    // NOTE: the array has no reset; it is wiped by the clear sweep instead,
    // which keeps it mappable onto RAM macros.
    if (wr_en) begin
      for (int k = 0; k < RPORTS; k++) begin
        mem_q[k][wr_addr] <= wr_data;
      end
    end
  end

  // Registered read returns; data holds while valid is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rw_rvalid_q <= 1'b0;
      rw_rdata_q  <= '0;
      r_rvalid_q  <= '0;
      r_rdata_q   <= '0;
    end else begin
      rw_rvalid_q <= rw_acc;
      if (rw_acc) begin
        rw_rdata_q <= rw_wen_i ? rw_wdata_i : mem_q[0][rw_addr_i];
      end
      r_rvalid_q <= r_acc;
      for (int k = 0; k < RPORTS; k++) begin
        if (r_acc[k]) r_rdata_q[k*DW +: DW] <= rd_word[k];
      end
    end
  end

  assign busy_o      = (state_q == CLEAR);
  assign rw_rdy_o    = ready;
  assign r_rdy_o     = {RPORTS{ready}};
  assign rw_rvalid_o = rw_rvalid_q;
  assign rw_rdata_o  = rw_rdata_q;
  assign r_rvalid_o  = r_rvalid_q;
  assign r_rdata_o   = r_rdata_q;

endmodule

// File: tb/tb_main_mem_mp.sv
// Testbench for main_mem_mp: two instances (write-first and read-first)
// share one stimulus stream and are compared against a behavioural model,
// plus a table of directed vectors and hand-written clear/reset sequences.
module tb_main_mem_mp;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int RP    = 3;
  localparam int DEPTH = 16;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b1;
  logic            clr_req_i;
  logic            rw_val_i, rw_wen_i;
  logic [AW-1:0]   rw_addr_i;
  logic [DW-1:0]   rw_wdata_i;
  logic [RP-1:0]   r_val_i;
  logic [RP*AW-1:0] r_addr_i;

  logic            busy1, rw_rdy1, rw_rv1;
  logic [DW-1:0]   rw_rd1;
  logic [RP-1:0]   r_rdy1, r_rv1;
  logic [RP*DW-1:0] r_rd1;
  logic            busy0, rw_rdy0, rw_rv0;
  logic [DW-1:0]   rw_rd0;
  logic [RP-1:0]   r_rdy0, r_rv0;
  logic [RP*DW-1:0] r_rd0;

  main_mem_mp #(.AW(AW), .DW(DW), .RPORTS(RP), .WRITE_FIRST(1)) u_wf1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_req_i(clr_req_i), .busy_o(busy1),
    .rw_val_i(rw_val_i), .rw_wen_i(rw_wen_i), .rw_addr_i(rw_addr_i),
    .rw_wdata_i(rw_wdata_i), .rw_rdy_o(rw_rdy1), .rw_rvalid_o(rw_rv1),
    .rw_rdata_o(rw_rd1), .r_val_i(r_val_i), .r_addr_i(r_addr_i),
    .r_rdy_o(r_rdy1), .r_rvalid_o(r_rv1), .r_rdata_o(r_rd1)
  );

  main_mem_mp #(.AW(AW), .DW(DW), .RPORTS(RP), .WRITE_FIRST(0)) u_wf0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_req_i(clr_req_i), .busy_o(busy0),
    .rw_val_i(rw_val_i), .rw_wen_i(rw_wen_i), .rw_addr_i(rw_addr_i),
    .rw_wdata_i(rw_wdata_i), .rw_rdy_o(rw_rdy0), .rw_rvalid_o(rw_rv0),
    .rw_rdata_o(rw_rd0), .r_val_i(r_val_i), .r_addr_i(r_addr_i),
    .r_rdy_o(r_rdy0), .r_rvalid_o(r_rv0), .r_rdata_o(r_rd0)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: word array, sweep countdown, expected read returns.
  logic [DW-1:0]    m_mem [DEPTH];
  bit               m_busy;
  int               m_cnt;
  logic             e_rw_v;
  logic [DW-1:0]    e_rw_d;
  logic [RP-1:0]    e_r_v;
  logic [RP*DW-1:0] e_rd1, e_rd0;

  typedef struct {
    logic             rw_val;
    logic             rw_wen;
    logic [AW-1:0]    rw_addr;
    logic [DW-1:0]    rw_wdata;
    logic [RP-1:0]    r_val;
    logic [RP*AW-1:0] r_addr;
    logic             exp_rw_v;
    logic [DW-1:0]    exp_rw_d;
    logic [RP-1:0]    exp_r_v;
    logic [RP*DW-1:0] exp_rd_wf1;
    logic [RP*DW-1:0] exp_rd_wf0;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    clr_req_i  = 1'b0;
    rw_val_i   = 1'b0;
    rw_wen_i   = 1'b0;
    rw_addr_i  = '0;
    rw_wdata_i = '0;
    r_val_i    = '0;
    r_addr_i   = '0;
  endtask

  task automatic rand_inputs();
    rw_val_i   = ($urandom_range(0, 3) != 0);
    rw_wen_i   = 1'($urandom_range(0, 1));
    rw_addr_i  = AW'($urandom_range(0, DEPTH - 1));
    rw_wdata_i = DW'($urandom);
    r_val_i    = RP'($urandom);
    for (int k = 0; k < RP; k++) begin
      r_addr_i[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? rw_addr_i
                                                         : AW'($urandom_range(0, DEPTH - 1));
    end
    clr_req_i = 1'b0;
  endtask

  // One clock: predict from the model, clock, then compare both instances.
  task automatic step();
    logic [AW-1:0] a;
    if (m_busy) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == DEPTH) begin
        m_busy = 1'b0;
        m_cnt  = 0;
      end
      e_rw_v = 1'b0;
      e_r_v  = '0;
    end else begin
      e_rw_v = rw_val_i;
      if (rw_val_i) e_rw_d = rw_wen_i ? rw_wdata_i : m_mem[rw_addr_i];
      e_r_v = r_val_i;
      for (int k = 0; k < RP; k++) begin
        if (r_val_i[k]) begin
          a = r_addr_i[k*AW +: AW];
          e_rd0[k*DW +: DW] = m_mem[a];
          e_rd1[k*DW +: DW] = (rw_val_i && rw_wen_i && a == rw_addr_i) ? rw_wdata_i : m_mem[a];
        end
      end
      if (rw_val_i && rw_wen_i) m_mem[rw_addr_i] = rw_wdata_i;
      if (clr_req_i) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
    @(posedge clk_i);
    #1;
    check("busy_wf1", busy1, m_busy);
    check("busy_wf0", busy0, m_busy);
    check("rw_rdy", {rw_rdy1, rw_rdy0}, {2{~m_busy}});
    check("r_rdy", {r_rdy1, r_rdy0}, {2{{RP{~m_busy}}}});
    check("rw_rvalid", {rw_rv1, rw_rv0}, {2{e_rw_v}});
    check("rw_rdata", {rw_rd1, rw_rd0}, {e_rw_d, e_rw_d});
    check("r_rvalid", {r_rv1, r_rv0}, {e_r_v, e_r_v});
    check("r_rdata_wf1", r_rd1, e_rd1);
    check("r_rdata_wf0", r_rd0, e_rd0);
    @(negedge clk_i);
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge.
  task automatic do_reset();
    #3;
    rst_ni = 1'b0;
    #1;
    m_busy = 1'b1;
    m_cnt  = 0;
    e_rw_v = 1'b0;
    e_rw_d = '0;
    e_r_v  = '0;
    e_rd1  = '0;
    e_rd0  = '0;
    check("rst_busy", {busy1, busy0}, 2'b11);
    check("rst_rdy", {rw_rdy1, rw_rdy0, r_rdy1, r_rdy0}, '0);
    check("rst_rvalid", {rw_rv1, rw_rv0, r_rv1, r_rv0}, '0);
    check("rst_rdata", {rw_rd1, rw_rd0, r_rd1, r_rd0}, '0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Count observed busy cycles (random requests meanwhile); bounded wait.
  task automatic count_busy(input string name);
    int n;
    n = busy1 ? 1 : 0;
    for (int i = 0; i < 4 * DEPTH && busy1; i++) begin
      rand_inputs();
      clr_req_i = 1'($urandom_range(0, 1));
      step();
      if (busy1) n++;
    end
    set_idle();
    check(name, n, DEPTH);
    check({name, "_done"}, busy1, 1'b0);
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < DEPTH; i++) begin
      set_idle();
      rw_val_i  = 1'b1;
      rw_addr_i = AW'(i);
      r_val_i   = '1;
      r_addr_i  = {RP{AW'(i)}};
      step();
      check("zero_rw", rw_rd1, 16'h0000);
      check("zero_r", r_rd1, '0);
    end
    set_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    vecs[0] = '{1'b1, 1'b1, 4'h5, 16'hBEEF, 3'b000, 12'h000,
                1'b1, 16'hBEEF, 3'b000, 48'h0, 48'h0};
    vecs[1] = '{1'b0, 1'b0, 4'h0, 16'h0000, 3'b010, 12'h050,
                1'b0, 16'h0000, 3'b010, 48'h0000_BEEF_0000, 48'h0000_BEEF_0000};
    vecs[2] = '{1'b1, 1'b1, 4'h3, 16'h1111, 3'b000, 12'h000,
                1'b1, 16'h1111, 3'b000, 48'h0, 48'h0};
    vecs[3] = '{1'b1, 1'b1, 4'h3, 16'h2222, 3'b001, 12'h003,
                1'b1, 16'h2222, 3'b001, 48'h0000_0000_2222, 48'h0000_0000_1111};
    vecs[4] = '{1'b0, 1'b0, 4'h0, 16'h0000, 3'b111, 12'h333,
                1'b0, 16'h0000, 3'b111, 48'h2222_2222_2222, 48'h2222_2222_2222};
    vecs[5] = '{1'b1, 1'b0, 4'h3, 16'h0000, 3'b100, 12'h500,
                1'b1, 16'h2222, 3'b100, 48'hBEEF_0000_0000, 48'hBEEF_0000_0000};
    vecs[6] = '{1'b1, 1'b0, 4'h0, 16'h0000, 3'b001, 12'h00F,
                1'b1, 16'h0000, 3'b001, 48'h0, 48'h0};

    set_idle();
    do_reset();
    count_busy("sweep_after_reset");
    read_all_zero();

    // Directed vectors: write/read, echo, and the same-cycle collision.
    for (int i = 0; i < 7; i++) begin
      rw_val_i   = vecs[i].rw_val;
      rw_wen_i   = vecs[i].rw_wen;
      rw_addr_i  = vecs[i].rw_addr;
      rw_wdata_i = vecs[i].rw_wdata;
      r_val_i    = vecs[i].r_val;
      r_addr_i   = vecs[i].r_addr;
      clr_req_i  = 1'b0;
      step();
      check($sformatf("vec%0d_rw_v", i), rw_rv1, vecs[i].exp_rw_v);
      if (vecs[i].exp_rw_v) check($sformatf("vec%0d_rw_d", i), rw_rd1, vecs[i].exp_rw_d);
      check($sformatf("vec%0d_r_v", i), {r_rv1, r_rv0}, {vecs[i].exp_r_v, vecs[i].exp_r_v});
      for (int k = 0; k < RP; k++) begin
        if (vecs[i].exp_r_v[k]) begin
          check($sformatf("vec%0d_p%0d_wf1", i, k), r_rd1[k*DW +: DW], vecs[i].exp_rd_wf1[k*DW +: DW]);
          check($sformatf("vec%0d_p%0d_wf0", i, k), r_rd0[k*DW +: DW], vecs[i].exp_rd_wf0[k*DW +: DW]);
        end
      end
    end
    set_idle();

    // Fill with 0xA5A5, then a clear request with a read served alongside.
    for (int i = 0; i < DEPTH; i++) begin
      rw_val_i = 1'b1; rw_wen_i = 1'b1; rw_addr_i = AW'(i); rw_wdata_i = 16'hA5A5;
      step();
    end
    set_idle();
    clr_req_i = 1'b1;
    r_val_i   = 3'b001;
    r_addr_i  = 12'h007;
    step();
    check("clr_same_cycle_read", {r_rv1[0], r_rd1[15:0]}, {1'b1, 16'hA5A5});
    count_busy("sweep_after_clr");
    read_all_zero();

    // Reset at sweep cycle 7: back to reset state, full sweep after release.
    clr_req_i = 1'b1;
    step();
    set_idle();
    repeat (6) step();
    check("busy_mid_sweep", busy1, 1'b1);
    do_reset();
    count_busy("sweep_after_mid_reset");

    // Distinct pattern, then all ports read 0..15 back-to-back.
    for (int i = 0; i < DEPTH; i++) begin
      rw_val_i = 1'b1; rw_wen_i = 1'b1; rw_addr_i = AW'(i);
      rw_wdata_i = DW'(i * 16'h1357 + 16'h0101);
      step();
    end
    set_idle();
    nv = 0;
    for (int i = 0; i < DEPTH; i++) begin
      r_val_i  = '1;
      r_addr_i = {RP{AW'(i)}};
      step();
      if (r_rv1 == 3'b111 && r_rv0 == 3'b111) nv++;
    end
    set_idle();
    check("b2b_valid_cycles", nv, DEPTH);

    // Randomized traffic with occasional clear requests.
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      clr_req_i = ($urandom_range(0, 199) == 0);
      step();
    end
    set_idle();
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
